innerproduct_mac: RTL and testbench



---
 rtl/innerproduct_pkg.sv | 24 ++
 rtl/innerproduct_mac_lanes.sv | 46 ++++
 rtl/innerproduct_mac.sv | 120 ++++++++++++
 tb/tb_innerproduct_mac.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/innerproduct_pkg.sv
// Shared types and helpers for the streaming inner-product MAC.
// Widths are derived per instance from its NFEAT/LANES parameters.
package innerproduct_pkg;

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

  // BCW: beat-counter width; never below 1 so a single-beat vector still has a counter bit.
  function automatic int calc_bcw(input int nbeat);
    return (nbeat > 1) ? $clog2(nbeat) : 1;
  endfunction

  // WAW: weight-address width covering bias plus NFEAT feature weights.
  function automatic int calc_waw(input int nfeat);
    return $clog2(nfeat + 1);
  endfunction

  // Unsigned feature times signed weight; callers truncate to AW, which keeps the result exact modulo 2^AW.
  function automatic logic signed [63:0] sext_prod(input logic [31:0] x, input logic signed [63:0] t);
    logic signed [63:0] xs;
    xs = $signed({32'b0, x});
    return xs * t;
  endfunction

endpackage

// File: rtl/innerproduct_mac_lanes.sv
// Stage 1 of the MAC: registers LANES weighted products per accepted beat, one cycle latency.
// No backpressure of its own; it samples whenever the parent signals a handshake.
module mac_lanes
  import innerproduct_pkg::*;
#(
  parameter int LANES = 1,
  parameter int XW    = 7,
  parameter int TW    = 32,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [LANES*XW-1:0]     x,
  input  logic [LANES*TW-1:0]     theta,
  output logic                    out_valid,
  output logic                    out_first,
  output logic signed [AW-1:0]    sum
);

  logic signed [AW-1:0] p [LANES];
  logic signed [AW-1:0] sum_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      for (int k = 0; k < LANES; k++) p[k] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_first <= in_first;
        for (int k = 0; k < LANES; k++)
          p[k] <= AW'(sext_prod(32'(x[k*XW +: XW]), 64'($signed(theta[k*TW +: TW]))));
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < LANES; k++) sum_c = sum_c + p[k];
    sum = sum_c;
  end

endmodule

// File: rtl/innerproduct_mac.sv
// Streaming inner product of NFEAT pixels with loadable weights plus shifted bias; result 2 cycles after last beat.
// Input stalls (s_ready low) in FLUSH/HOLD until the result is taken; weights writable only while idle.
module innerproduct_mac
  import innerproduct_pkg::*;
#(
  parameter int NFEAT      = 80,
  parameter int LANES      = 1,
  parameter int XW         = 7,
  parameter int TW         = 32,
  parameter int AW         = 32,
  parameter int BIAS_SHIFT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_we,
  input  logic [$clog2(NFEAT+1)-1:0]   w_addr,
  input  logic [TW-1:0]                w_data,
  output logic                         w_ready,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [LANES*XW-1:0]          s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [AW-1:0]                m_data,
  output logic                         m_err
);

  localparam int NBEAT = NFEAT / LANES;
  localparam int BCW   = calc_bcw(NBEAT);
  localparam int WAW   = calc_waw(NFEAT);

  state_t state_q, state_d;
  logic [BCW-1:0] bc;
  logic signed [TW-1:0] theta [NFEAT+1];
  logic [LANES*TW-1:0] th_lanes;
  logic hs, bc_last;
  logic s1_valid, s1_first, s1_mis;
  logic signed [AW-1:0] s1_sum, acc, bias;
  logic err;

  assign bc_last = (bc == BCW'(NBEAT - 1));
  assign hs      = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    w_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        s_ready = 1'b1;
        w_ready = (bc == '0) && !s1_valid;
        if (s_valid && bc_last) state_d = FLUSH;
      end
      FLUSH: state_d = HOLD;
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     bc <= '0;
    else if (hs) bc <= bc_last ? '0 : bc + BCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NFEAT; i++) theta[i] <= '0;
    end else if (w_we && w_ready && (int'(w_addr) <= NFEAT)) begin
      theta[w_addr] <= w_data;
    end
  end

  // Lane k of beat bc multiplies feature bc*LANES+k+1; index 0 is reserved for the bias.
  for (genvar k = 0; k < LANES; k++) begin : g_rd
    assign th_lanes[k*TW +: TW] = theta[WAW'(int'(bc) * LANES + k + 1)];
  end

  mac_lanes #(.LANES(LANES), .XW(XW), .TW(TW), .AW(AW)) u_lanes (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hs),
    .in_first  (bc == '0),
    .x         (s_data),
    .theta     (th_lanes),
    .out_valid (s1_valid),
    .out_first (s1_first),
    .sum       (s1_sum)
  );

  assign bias = AW'(theta[0]) <<< BIAS_SHIFT;

  // The s_last mismatch rides alongside stage 1 so a bad first beat is not wiped by its own clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      err    <= 1'b0;
      s1_mis <= 1'b0;
    end else begin
      if (hs) s1_mis <= s_last ^ bc_last;
      if (s1_valid) begin
        acc <= (s1_first ? bias : acc) + s1_sum;
        err <= (s1_first ? 1'b0 : err) | s1_mis;
      end
    end
  end

  assign m_data = acc;
  assign m_err  = err;

endmodule

// File: tb/tb_innerproduct_mac.sv
// Randomised scoreboard bench: stimulus pushes model results, a negedge monitor pops and compares.
module tb_innerproduct_mac;

  localparam int NFEAT = 80;
  localparam int LANES = 4;
  localparam int XW    = 7;
  localparam int TW    = 32;
  localparam int AW    = 32;
  localparam int BS    = 16;
  localparam int NB    = NFEAT / LANES;
  localparam int WAW   = $clog2(NFEAT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_we = 1'b0;
  logic [WAW-1:0] w_addr = '0;
  logic [TW-1:0] w_data = '0;
  logic w_ready;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [LANES*XW-1:0] s_data = '0;
  logic s_last = 1'b0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [AW-1:0] m_data;
  logic m_err;

  innerproduct_mac #(
    .NFEAT(NFEAT), .LANES(LANES), .XW(XW), .TW(TW), .AW(AW), .BIAS_SHIFT(BS)
  ) dut (
    .clk(clk), .rst(rst),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] d;
    logic          e;
    int            c;
  } exp_t;

  exp_t   q[$];
  exp_t   me;
  longint wt[NFEAT+1];
  int     xv[NFEAT+1];
  int     passes = 0;
  int     total  = 0;
  int     cyc    = 0;
  int     mr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  bit pv = 0, px = 0;
  logic [AW-1:0] pd;
  logic pe;

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
      px = 0;
    end else begin
      if (px) chk(!m_valid && s_ready, "release", {m_valid, s_ready}, 1);
      if (m_valid) begin
        chk(!s_ready, "s_ready_in_hold", s_ready, 0);
        if (!pv) begin
          chk(q.size() > 0, "result_expected", q.size(), 1);
          if (q.size() > 0) chk(cyc == q[0].c + 2, "latency", cyc - q[0].c, 2);
        end else if (!px) begin
          chk(m_data == pd && m_err == pe, "hold_stable", {m_err, m_data}, {pe, pd});
        end
        if (m_ready && q.size() > 0) begin
          me = q.pop_front();
          chk(m_data == me.d, "m_data", m_data, me.d);
          chk(m_err == me.e, "m_err", m_err, me.e);
        end
      end
      pv = m_valid;
      px = m_valid && m_ready;
      pd = m_data;
      pe = m_err;
    end
  end

  task automatic drive_beat(input logic [LANES*XW-1:0] d, input logic last, output int hc);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk(1'b0, "beat_timeout", n, 0);
    hc = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic write_w(input int a, input logic [TW-1:0] v);
    int n = 0;
    w_we   = 1'b1;
    w_addr = WAW'(a);
    w_data = v;
    @(negedge clk);
    while (!w_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!w_ready) chk(1'b0, "wready_timeout", n, 0);
    else if (a <= NFEAT) wt[a] = longint'($signed(v));
    @(posedge clk);
    #1;
    w_we = 1'b0;
  endtask

  // Reference: bias*2^BS plus dot product, reduced modulo 2^AW; s_last must be high exactly on the final beat.
  task automatic send_vector(input int bad_beat, input bit drop_last, input bit gaps, input int wr_beat);
    longint acc;
    bit mis = 0;
    int hc = 0;
    logic [LANES*XW-1:0] d;
    logic l;
    exp_t e;
    acc = wt[0] <<< BS;
    for (int i = 1; i <= NFEAT; i++) acc += longint'(xv[i]) * wt[i];
    for (int b = 0; b < NB; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int k = 0; k < LANES; k++) d[k*XW +: XW] = XW'(xv[b*LANES + k + 1]);
      l = (b == NB - 1) ? !drop_last : (b == bad_beat);
      if (l != (b == NB - 1)) mis = 1;
      if (b == wr_beat) begin
        w_we = 1'b1; w_addr = WAW'(5); w_data = $urandom;
      end
      drive_beat(d, l, hc);
      if (b == wr_beat) begin
        w_we = 1'b0;
        chk(!w_ready, "w_ready_busy", w_ready, 0);
      end
    end
    e.d = acc[AW-1:0];
    e.e = mis;
    e.c = hc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk(1'b0, "drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_x();
    for (int i = 1; i <= NFEAT; i++) xv[i] = $urandom_range(0, 127);
  endtask

  initial begin
    int n;
    int hc;
    logic [LANES*XW-1:0] d;
    for (int i = 0; i <= NFEAT; i++) wt[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(s_ready == 1'b1, "rst_s_ready", s_ready, 1);
    chk(w_ready == 1'b1, "rst_w_ready", w_ready, 1);
    chk(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
    chk(m_data == '0, "rst_m_data", m_data, 0);
    chk(m_err == 1'b0, "rst_m_err", m_err, 0);
    @(posedge clk);
    #1;

    // bias 2, unit weights, unit pixels
    write_w(0, 32'd2);
    for (int i = 1; i <= NFEAT; i++) write_w(i, 32'd1);
    for (int i = 1; i <= NFEAT; i++) xv[i] = 1;
    send_vector(-1, 0, 0, -1);
    drain();

    // all weights -1, saturated pixels
    write_w(0, 32'd0);
    for (int i = 1; i <= NFEAT; i++) write_w(i, 32'hFFFF_FFFF);
    for (int i = 1; i <= NFEAT; i++) xv[i] = 127;
    send_vector(-1, 0, 0, -1);
    drain();

    for (int i = 0; i <= NFEAT; i++) write_w(i, $urandom);
    write_w(100, $urandom);

    // result parked with m_ready low
    rand_x();
    mr_mode = 2;
    send_vector(-1, 0, 0, -1);
    n = 0;
    while (!m_valid && n < 50) begin @(negedge clk); n++; end
    if (!m_valid) chk(1'b0, "hold_timeout", n, 0);
    repeat (10) @(negedge clk);
    mr_mode = 0;
    drain();

    // early s_last, missing final s_last, then a clean vector
    rand_x();
    send_vector(NB / 2 - 1, 1, 0, -1);
    drain();
    rand_x();
    send_vector(-1, 0, 0, -1);
    drain();

    // write attempt mid-vector, then one-hot readback of theta[5]
    rand_x();
    send_vector(-1, 0, 0, 7);
    drain();
    for (int i = 1; i <= NFEAT; i++) xv[i] = 0;
    xv[5] = 1;
    send_vector(-1, 0, 0, -1);
    drain();

    mr_mode = 1;
    for (int v = 0; v < 6; v++) begin
      rand_x();
      send_vector(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 2)) : -1, 0, 1, -1);
    end
    mr_mode = 0;
    drain();

    // reset in the middle of a vector
    rand_x();
    for (int b = 0; b < 7; b++) begin
      for (int k = 0; k < LANES; k++) d[k*XW +: XW] = XW'(xv[b*LANES + k + 1]);
      drive_beat(d, 1'b0, hc);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= NFEAT; i++) wt[i] = 0;
    @(negedge clk);
    chk(m_valid == 1'b0, "rst2_m_valid", m_valid, 0);
    chk(s_ready == 1'b1, "rst2_s_ready", s_ready, 1);
    chk(w_ready == 1'b1, "rst2_w_ready", w_ready, 1);
    @(posedge clk);
    #1;
    rand_x();
    send_vector(-1, 0, 0, -1);
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
